// File: rtl/wvb_wr_addr_ctrl.sv
// wvb_wr_addr_ctrl
// Write-side address and event controller for the mDOM waveform buffer.
// While armed, ADC samples go into the circular sample RAM every cycle. An
// accepted trigger opens an event window of pre_conf samples before the
// trigger sample and post_conf samples after it. When the window closes the
// event is committed and a header (start, stop, LTC, truncation flag) is
// written into the header FIFO for the read side.
// Samples of events the reader has not yet released are protected: the write
// pointer stalls one slot short of the oldest protected address (the guard),
// so the longest possible event is 2^P_ADR_WIDTH-1 samples.
module wvb_wr_addr_ctrl #(
   parameter int P_ADR_WIDTH = 12,
   parameter int P_LTC_WIDTH = 48,
   parameter int P_PRE_WIDTH = 5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic                   trig,
   input  logic [P_LTC_WIDTH-1:0] ltc,
   input  logic [P_PRE_WIDTH-1:0] pre_conf,
   input  logic [P_ADR_WIDTH-1:0] post_conf,
   input  logic                   hdr_full,
   input  logic                   rel,
   input  logic [P_ADR_WIDTH-1:0] rel_addr,
   output logic [P_ADR_WIDTH-1:0] wvb_wr_addr,
   output logic                   wvb_wren,
   output logic                   hdr_wr,
   output logic [P_ADR_WIDTH-1:0] hdr_start_addr,
   output logic [P_ADR_WIDTH-1:0] hdr_stop_addr,
   output logic [P_LTC_WIDTH-1:0] hdr_evt_ltc,
   output logic                   hdr_trunc,
   output logic                   trig_drop,
   output logic                   busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   localparam logic [P_ADR_WIDTH-1:0] ADR_ONE = P_ADR_WIDTH'(1);
   localparam logic [P_PRE_WIDTH-1:0] PRE_ONE = P_PRE_WIDTH'(1);

   state_t state;
   state_t state_nxt;

   // current event bookkeeping
   logic [P_ADR_WIDTH-1:0] cur_start;
   logic [P_ADR_WIDTH-1:0] cur_stop_tgt;
   logic [P_LTC_WIDTH-1:0] cur_ltc;

   // pretrigger continuity counter
   logic [P_PRE_WIDTH-1:0] pre_cnt;

   // outstanding (committed, unreleased) events and start of protected region
   logic [P_ADR_WIDTH-1:0] evt_cnt;
   logic [P_ADR_WIDTH-1:0] free_ptr;

   // overwrite guard
   logic                   guard_vld;
   logic [P_ADR_WIDTH-1:0] guard;
   logic [P_ADR_WIDTH-1:0] wr_addr_inc;
   logic                   full;

   // trigger acceptance
   logic [P_ADR_WIDTH-1:0] pre_ext;
   logic [P_ADR_WIDTH-1:0] acc_start;
   logic [P_ADR_WIDTH-1:0] acc_stop_tgt;
   logic                   accept;
   logic                   trig_drop_nxt;

   // commit of an event, decided by the FSM
   logic                   commit;
   logic                   commit_trunc;
   logic [P_ADR_WIDTH-1:0] commit_start;
   logic [P_ADR_WIDTH-1:0] commit_stop;
   logic [P_LTC_WIDTH-1:0] commit_ltc;

   // a release pulse only counts when something is outstanding
   logic                   rel_eff;

   // Guard is the oldest address that must not be overwritten: the oldest
   // unreleased event if any, else the start of the event being captured.
   always_comb begin
      guard_vld   = (evt_cnt != '0) || (state == CAPTURE);
      guard       = (evt_cnt != '0) ? free_ptr : cur_start;
      wr_addr_inc = wvb_wr_addr + ADR_ONE;
      full        = guard_vld && (wr_addr_inc == guard);
   end

   assign wvb_wren = (state != IDLE) && !full;
   assign busy     = (state == CAPTURE);

   // Trigger acceptance needs a full pretrigger history and room in the header FIFO.
   always_comb begin
      pre_ext       = P_ADR_WIDTH'(pre_conf);
      acc_start     = wvb_wr_addr - pre_ext;
      acc_stop_tgt  = wvb_wr_addr + post_conf;
      accept        = (state == ARMED) && en && trig && wvb_wren &&
                      (pre_cnt >= pre_conf) && !hdr_full;
      trig_drop_nxt = trig && !accept && ((state == ARMED) || (state == CAPTURE));
      rel_eff       = rel && (evt_cnt != '0);
   end

   // Next-state and commit decision; a zero post window commits in the trigger cycle.
   always_comb begin
      state_nxt    = state;
      commit       = 1'b0;
      commit_trunc = 1'b0;
      commit_start = cur_start;
      commit_stop  = wvb_wr_addr;
      commit_ltc   = cur_ltc;
      case (state)
         IDLE: begin
            if (en) begin
               state_nxt = ARMED;
            end
         end
         ARMED: begin
            if (!en) begin
               state_nxt = IDLE;
            end else if (accept) begin
               if (post_conf == '0) begin
                  commit       = 1'b1;
                  commit_start = acc_start;
                  commit_stop  = wvb_wr_addr;
                  commit_ltc   = ltc;
               end else begin
                  state_nxt = CAPTURE;
               end
            end
         end
         CAPTURE: begin
            if (wvb_wren && (wvb_wr_addr == cur_stop_tgt)) begin
               commit      = 1'b1;
               commit_stop = wvb_wr_addr;
            end else if (full) begin
               commit       = 1'b1;
               commit_trunc = 1'b1;
               commit_stop  = wvb_wr_addr - ADR_ONE;
            end
            if (commit) begin
               state_nxt = en ? ARMED : IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Sample RAM write pointer advances after every performed write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wvb_wr_addr <= '0;
      end else if (wvb_wren) begin
         wvb_wr_addr <= wr_addr_inc;
      end
   end

   // Pretrigger counter: restarts on arming, after a commit and whenever a stall breaks continuity.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
      end else if (state == IDLE) begin
         pre_cnt <= '0;
      end else if (commit) begin
         pre_cnt <= '0;
      end else if (state == ARMED) begin
         if (full) begin
            pre_cnt <= '0;
         end else if (wvb_wren && (pre_cnt < pre_conf)) begin
            pre_cnt <= pre_cnt + PRE_ONE;
         end
      end
   end

   // Latch the window bounds and trigger time of an accepted trigger.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_start    <= '0;
         cur_stop_tgt <= '0;
         cur_ltc      <= '0;
      end else if (accept) begin
         cur_start    <= acc_start;
         cur_stop_tgt <= acc_stop_tgt;
         cur_ltc      <= ltc;
      end
   end

   // Track outstanding events and the start of the region the reader still owns.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_cnt  <= '0;
         free_ptr <= '0;
      end else if (commit && rel_eff) begin
         if (evt_cnt == ADR_ONE) begin
            free_ptr <= commit_start;
         end else begin
            free_ptr <= rel_addr;
         end
      end else if (commit) begin
         evt_cnt <= evt_cnt + ADR_ONE;
         if (evt_cnt == '0) begin
            free_ptr <= commit_start;
         end
      end else if (rel_eff) begin
         evt_cnt <= evt_cnt - ADR_ONE;
         if (evt_cnt > ADR_ONE) begin
            free_ptr <= rel_addr;
         end
      end
   end

   // Header write is a one-cycle pulse following the commit, fields held afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hdr_wr         <= 1'b0;
         hdr_start_addr <= '0;
         hdr_stop_addr  <= '0;
         hdr_evt_ltc    <= '0;
         hdr_trunc      <= 1'b0;
      end else begin
         hdr_wr <= commit;
         if (commit) begin
            hdr_start_addr <= commit_start;
            hdr_stop_addr  <= commit_stop;
            hdr_evt_ltc    <= commit_ltc;
            hdr_trunc      <= commit_trunc;
         end
      end
   end

   // Report a trigger that was seen while armed or capturing but not accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trig_drop <= 1'b0;
      end else begin
         trig_drop <= trig_drop_nxt;
      end
   end

endmodule
